// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath control selects, counts retired instructions and flags illegal opcodes.
module mips_mc_controller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_wr,
    output logic             ir_wr,
    output logic             reg_wr,
    output logic             mem_wr,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       ext_op,
    output logic [1:0]       alu_ctr,
    output logic [1:0]       pc_sel,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_R_EXEC  = 4'd2,
        S_R_WB    = 4'd3,
        S_I_EXEC  = 4'd4,
        S_I_WB    = 4'd5,
        S_MEM_ADR = 4'd6,
        S_MEM_RD  = 4'd7,
        S_MEM_WB  = 4'd8,
        S_MEM_WR  = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_JR      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;

    logic is_rtype, is_r_alu, is_jr, is_mem, is_imm, is_jump;

    always_comb begin
        is_rtype = (opcode == OP_RTYPE);
        is_r_alu = is_rtype && ((funct == FN_ADDU) || (funct == FN_SUBU));
        is_jr    = is_rtype && (funct == FN_JR);
        is_mem   = (opcode == OP_LW) || (opcode == OP_SW);
        is_imm   = (opcode == OP_ORI) || (opcode == OP_ADDI) || (opcode == OP_LUI);
        is_jump  = (opcode == OP_J) || (opcode == OP_JAL);
    end

    always_comb begin
        state_d     = S_FETCH;
        pc_wr       = 1'b0;
        ir_wr       = 1'b0;
        reg_wr      = 1'b0;
        mem_wr      = 1'b0;
        reg_dst     = 2'b00;
        mem_to_reg  = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        ext_op      = 2'b00;
        alu_ctr     = 2'b00;
        pc_sel      = 2'b00;
        instr_done  = 1'b0;
        illegal     = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_wr     = 1'b1;
                pc_wr     = 1'b1;
                alu_src_b = 2'b01;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                ext_op    = 2'b01;
                if (is_r_alu)                 state_d = S_R_EXEC;
                else if (is_jr)               state_d = S_JR;
                else if (is_mem)              state_d = S_MEM_ADR;
                else if (is_imm)              state_d = S_I_EXEC;
                else if (opcode == OP_BEQ)    state_d = S_BRANCH;
                else if (is_jump)             state_d = S_JUMP;
                else begin
                    // Unsupported encodings retire here as a NOP.
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_ctr   = (funct == FN_SUBU) ? 2'b01 : 2'b00;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_wr     = 1'b1;
                reg_dst    = 2'b01;
                instr_done = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_ORI:  begin ext_op = 2'b00; alu_ctr = 2'b10; end
                    OP_LUI:  begin ext_op = 2'b10; alu_ctr = 2'b11; end
                    default: begin ext_op = 2'b01; alu_ctr = 2'b00; end
                endcase
                state_d = S_I_WB;
            end
            S_I_WB: begin
                reg_wr     = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 2'b01;
                state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 2'b01;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_wr     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_ctr    = 2'b01;
                pc_sel     = 2'b01;
                pc_wr      = zero;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_wr      = 1'b1;
                pc_sel     = 2'b10;
                instr_done = 1'b1;
                if (opcode == OP_JAL) begin
                    reg_wr     = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end
            end
            S_JR: begin
                pc_wr      = 1'b1;
                pc_sel     = 2'b11;
                instr_done = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset dominates every enable and select, including the retire pulse.
        if (rst) begin
            pc_wr      = 1'b0;
            ir_wr      = 1'b0;
            reg_wr     = 1'b0;
            mem_wr     = 1'b0;
            reg_dst    = 2'b00;
            mem_to_reg = 2'b00;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            ext_op     = 2'b00;
            alu_ctr    = 2'b00;
            pc_sel     = 2'b00;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end

        instr_cnt_d = instr_done ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign instr_cnt = instr_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: directed and randomized instruction
// streams compared per cycle against an instruction-level reference model.
module tb_mips_mc_controller;

    localparam int unsigned CW = 4;

    typedef struct packed {
        logic       pc_wr, ir_wr, reg_wr, mem_wr;
        logic [1:0] reg_dst, mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b, ext_op, alu_ctr, pc_sel;
        logic       instr_done, illegal;
    } ctrl_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    opcode, funct;
    logic          zero;
    logic          pc_wr, ir_wr, reg_wr, mem_wr, alu_src_a, instr_done, illegal;
    logic [1:0]    reg_dst, mem_to_reg, alu_src_b, ext_op, alu_ctr, pc_sel;
    logic [CW-1:0] instr_cnt;
    logic [3:0]    state;
    ctrl_t         obs;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    mips_mc_controller #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_wr(pc_wr), .ir_wr(ir_wr), .reg_wr(reg_wr), .mem_wr(mem_wr),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_ctr(alu_ctr), .pc_sel(pc_sel),
        .instr_done(instr_done), .illegal(illegal), .instr_cnt(instr_cnt), .state(state)
    );

    always #5 clk = ~clk;

    assign obs = ctrl_t'({pc_wr, ir_wr, reg_wr, mem_wr, reg_dst, mem_to_reg, alu_src_a,
                          alu_src_b, ext_op, alu_ctr, pc_sel, instr_done, illegal});

    function automatic logic legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: legal = (fn == 6'b100001) || (fn == 6'b100011) || (fn == 6'b001000);
            6'b100011, 6'b101011, 6'b001101, 6'b001000, 6'b001111,
            6'b000100, 6'b000010, 6'b000011: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    endfunction

    // Instruction class -> ordered list of visited states.
    task automatic get_seq(input logic [5:0] op, input logic [5:0] fn,
                           output int n, output int s [5]);
        s = '{0, 1, 0, 0, 0};
        if (!legal(op, fn))              n = 2;
        else if (op == 6'b000000) begin
            if (fn == 6'b001000) begin n = 3; s[2] = 12; end
            else                 begin n = 4; s[2] = 2; s[3] = 3; end
        end
        else if (op == 6'b100011) begin n = 5; s[2] = 6; s[3] = 7; s[4] = 8; end
        else if (op == 6'b101011) begin n = 4; s[2] = 6; s[3] = 9; end
        else if (op == 6'b000100) begin n = 3; s[2] = 10; end
        else if (op == 6'b000010 || op == 6'b000011) begin n = 3; s[2] = 11; end
        else                      begin n = 4; s[2] = 4; s[3] = 5; end
    endtask

    function automatic ctrl_t exp_ctrl(input int st, input logic [5:0] op,
                                       input logic [5:0] fn, input logic z);
        ctrl_t c;
        c = '0;
        case (st)
            0:  begin c.ir_wr = 1; c.pc_wr = 1; c.alu_src_b = 2'b01; end
            1:  begin
                    c.alu_src_b = 2'b11; c.ext_op = 2'b01;
                    if (!legal(op, fn)) begin c.illegal = 1; c.instr_done = 1; end
                end
            2:  begin c.alu_src_a = 1; c.alu_ctr = (fn == 6'b100011) ? 2'b01 : 2'b00; end
            3:  begin c.reg_wr = 1; c.reg_dst = 2'b01; c.instr_done = 1; end
            4:  begin
                    c.alu_src_a = 1; c.alu_src_b = 2'b10;
                    if (op == 6'b001101)      begin c.ext_op = 2'b00; c.alu_ctr = 2'b10; end
                    else if (op == 6'b001111) begin c.ext_op = 2'b10; c.alu_ctr = 2'b11; end
                    else                      begin c.ext_op = 2'b01; c.alu_ctr = 2'b00; end
                end
            5:  begin c.reg_wr = 1; c.instr_done = 1; end
            6:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.ext_op = 2'b01; end
            8:  begin c.reg_wr = 1; c.mem_to_reg = 2'b01; c.instr_done = 1; end
            9:  begin c.mem_wr = 1; c.instr_done = 1; end
            10: begin
                    c.alu_src_a = 1; c.alu_ctr = 2'b01; c.pc_sel = 2'b01;
                    c.pc_wr = z; c.instr_done = 1;
                end
            11: begin
                    c.pc_wr = 1; c.pc_sel = 2'b10; c.instr_done = 1;
                    if (op == 6'b000011) begin
                        c.reg_wr = 1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
                    end
                end
            12: begin c.pc_wr = 1; c.pc_sel = 2'b11; c.instr_done = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Entered just after a rising edge with the DUT in FETCH; runs `upto` cycles
    // of the instruction (all of it when upto >= its length).
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int upto);
        int n;
        int s [5];
        ctrl_t e;
        get_seq(op, fn, n, s);
        opcode = op; funct = fn; zero = z;
        for (int i = 0; i < n && i < upto; i++) begin
            @(negedge clk);
            e = exp_ctrl(s[i], op, fn, z);
            checks++;
            if (state !== 4'(s[i])) begin
                errors++;
                $display("FAIL %s state cyc%0d got %0d want %0d", name, i, state, s[i]);
            end
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s ctrl cyc%0d st%0d got %b want %b", name, i, s[i], obs, e);
            end
            if (i < upto - 1) begin
                @(posedge clk); #1;
            end
        end
        if (upto >= n) begin
            exp_cnt = (exp_cnt + 1) % (1 << CW);
            checks++;
            if (instr_cnt !== CW'(exp_cnt)) begin
                errors++;
                $display("FAIL %s instr_cnt got %0d want %0d", name, instr_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; opcode = 6'($urandom); funct = 6'($urandom); zero = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== ctrl_t'('0)) begin
                errors++;
                $display("FAIL reset ctrl cyc%0d got %b want 0", i, obs);
            end
            checks++;
            if (state !== 4'd0 || instr_cnt !== '0) begin
                errors++;
                $display("FAIL reset state/cnt got %0d/%0d want 0/0", state, instr_cnt);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_directed();
        run_instr("addu", 6'b000000, 6'b100001, 1'b0, 9);
        run_instr("subu", 6'b000000, 6'b100011, 1'b1, 9);
        run_instr("lw",   6'b100011, 6'b000000, 1'b0, 9);
        run_instr("sw",   6'b101011, 6'b111111, 1'b0, 9);
        run_instr("ori",  6'b001101, 6'b000000, 1'b0, 9);
        run_instr("addi", 6'b001000, 6'b000000, 1'b0, 9);
        run_instr("lui",  6'b001111, 6'b000000, 1'b0, 9);
        run_instr("beq1", 6'b000100, 6'b000000, 1'b1, 9);
        run_instr("beq0", 6'b000100, 6'b000000, 1'b0, 9);
        run_instr("jal",  6'b000011, 6'b000000, 1'b0, 9);
        run_instr("j",    6'b000010, 6'b000000, 1'b0, 9);
        run_instr("jr",   6'b000000, 6'b001000, 1'b0, 9);
        run_instr("ill",  6'b111111, 6'b000000, 1'b0, 9);
        run_instr("slt",  6'b000000, 6'b101010, 1'b0, 9);
    endtask

    // Abort an instruction by raising rst during its k-th cycle (0-based).
    task automatic test_abort(input string name, input logic [5:0] op,
                              input logic [5:0] fn, input int k);
        run_instr(name, op, fn, 1'b0, k);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== ctrl_t'('0)) begin
            errors++;
            $display("FAIL %s abort ctrl got %b want 0", name, obs);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 0;
        checks++;
        if (state !== 4'd0 || instr_cnt !== '0) begin
            errors++;
            $display("FAIL %s abort state/cnt got %0d/%0d want 0/0", name, state, instr_cnt);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [9] = '{6'b000000, 6'b100011, 6'b101011, 6'b001101, 6'b001000,
                                6'b001111, 6'b000100, 6'b000010, 6'b000011};
        logic [5:0] fns [5] = '{6'b100001, 6'b100011, 6'b001000, 6'b101010, 6'b000000};
        logic [5:0] op, fn;
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
            fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_instr("rand", op, fn, 1'($urandom), 9);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_abort("lw_memrd", 6'b100011, 6'b000000, 3);
        run_instr("addu", 6'b000000, 6'b100001, 1'b0, 9);
        run_instr("sw",   6'b101011, 6'b000000, 1'b0, 9);
        test_abort("addu_wb", 6'b000000, 6'b100001, 3);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
- Multi-cycle control FSM for the MIPS core. It is the responder to the datapath's opcode/funct outputs.
- It reads opcode, funct and the ALU zero flag from a datapath holding an instruction register. It sequences FETCH/DECODE/EXEC/MEM/WB and drives per-state control signals.
- It replaces the single-cycle combinational controller and keeps the same control encodings.
- It also counts retired instructions and flags illegal opcodes.

Parameters:
- CNT_W, 32, width of retired-instruction counter instr_cnt.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous active-high reset.
- opcode  input  6  IR[31:26] from datapath; stable from DECODE until next FETCH.
- funct  input  6  IR[5:0] from datapath.
- zero  input  1  ALU zero flag, valid in the BRANCH state.
- pc_wr  output  1  PC register write enable.
- ir_wr  output  1  instruction register write enable.
- reg_wr  output  1  register file write enable.
- mem_wr  output  1  data memory write enable.
- reg_dst  output  2  00 rt, 01 rd, 10 $31.
- mem_to_reg  output  2  00 ALUOut, 01 MDR, 10 PC (return addr).
- alu_src_a  output  1  0 PC, 1 rs.
- alu_src_b  output  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2.
- ext_op  output  2  00 zero-ext, 01 sign-ext, 10 imm<<16.
- alu_ctr  output  2  00 add, 01 sub, 10 or, 11 pass B.
- pc_sel  output  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 rs (jr).
- instr_done  output  1  one-cycle pulse in the last state of each instruction.
- illegal  output  1  one-cycle pulse in DECODE on an unsupported opcode/funct.
- instr_cnt  output  CNT_W  retired-instruction count.
- state  output  4  current state, for debug.

Behaviour:
- Reset: when rst=1 at a rising edge, state <= FETCH and instr_cnt <= 0.
- While rst=1, all enables and pulses (pc_wr, ir_wr, reg_wr, mem_wr, instr_done, illegal) are forced to 0 and all selects to 00/0.
- Reset mid-instruction aborts it with no partial write after the reset edge.
- Outputs are Moore-decoded from state. In DECODE and later states they also depend on the combinational opcode/funct.
- States and control per state:
  - FETCH (0): ir_wr=1, pc_wr=1, alu_src_a=0, alu_src_b=01, alu_ctr=00, pc_sel=00. Next: DECODE.
  - DECODE (1): alu_src_a=0, alu_src_b=11, ext_op=01, alu_ctr=00 (branch target into ALUOut). Next state by opcode:
    - 000000 with funct 100001 addu, 100011 subu, 101010->treated illegal: R_EXEC.
    - 000000 with funct 001000 jr: JR.
    - 100011 lw / 101011 sw: MEM_ADR.
    - 001101 ori / 001000 addi / 001111 lui: I_EXEC.
    - 000100 beq: BRANCH.
    - 000010 j / 000011 jal: JUMP.
    - Anything else: illegal=1, instr_done=1, next FETCH (executes as NOP).
  - R_EXEC (2): alu_src_a=1, alu_src_b=00, alu_ctr=00 addu / 01 subu. Next: R_WB.
  - R_WB (3): reg_wr=1, reg_dst=01, mem_to_reg=00, instr_done=1. Next: FETCH.
  - I_EXEC (4): alu_src_a=1, alu_src_b=10. Next: I_WB.
    - ori: ext_op=00, alu_ctr=10.
    - addi: ext_op=01, alu_ctr=00.
    - lui: ext_op=10, alu_ctr=11.
  - I_WB (5): reg_wr=1, reg_dst=00, mem_to_reg=00, instr_done=1. Next: FETCH.
  - MEM_ADR (6): alu_src_a=1, alu_src_b=10, ext_op=01, alu_ctr=00. Next: MEM_RD for lw, MEM_WR for sw.
  - MEM_RD (7): no enables. Next: MEM_WB.
  - MEM_WB (8): reg_wr=1, reg_dst=00, mem_to_reg=01, instr_done=1. Next: FETCH.
  - MEM_WR (9): mem_wr=1, instr_done=1. Next: FETCH.
  - BRANCH (10): alu_src_a=1, alu_src_b=00, alu_ctr=01, pc_sel=01, pc_wr=zero, instr_done=1. Next: FETCH.
  - JUMP (11): pc_wr=1, pc_sel=10, instr_done=1. Next: FETCH.
    - jal also asserts reg_wr=1, reg_dst=10, mem_to_reg=10. PC already holds PC+4.
  - JR (12): pc_wr=1, pc_sel=11, instr_done=1. Next: FETCH.
  - Codes 13-15: unreachable. Treat as FETCH next, with all enables 0.
- Latency in cycles, FETCH included:
  - 5: lw.
  - 4: R-type, I-type, sw.
  - 3: beq, j, jal, jr.
  - 2: illegal.
- Exactly one instr_done pulse per instruction, including illegal.
- instr_cnt increments on every clock edge where instr_done=1 and rst=0. It wraps from 2^CNT_W-1 to 0.
- Simultaneous rst and instr_done: reset wins; instr_cnt becomes 0.
- At most one of reg_wr/mem_wr is high in any cycle.
- pc_wr is high only in FETCH, BRANCH (gated by zero), JUMP and JR.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 -> state=0, instr_cnt=0, all enables 0 while rst=1. The first cycle after release has ir_wr=pc_wr=1.
- addu (opcode 000000, funct 100001) -> states 0,1,2,3. Cycle 4 has reg_wr=1, reg_dst=01, alu_ctr=00 in R_EXEC. instr_cnt increments to 1.
- lw (100011) then sw (101011) -> 5 then 4 cycles. MEM_WB has mem_to_reg=01. MEM_WR has mem_wr=1 and reg_wr=0. instr_cnt +2.
- beq with zero=1, then zero=0 -> pc_wr=1 then pc_wr=0 in state 10. Both take 3 cycles with pc_sel=01.
- jal (000011) -> state 11 with pc_wr=1, pc_sel=10, reg_wr=1, reg_dst=10, mem_to_reg=10. jr (funct 001000) -> state 12 with pc_sel=11.
- opcode 111111 -> illegal=1 and instr_done=1 in DECODE, then back to FETCH. Also: rst=1 asserted during MEM_RD -> no reg_wr, state=0 next.
